mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_ctrl_pkg.sv | 84 ++++++++
 rtl/mc_ctrl_ras.sv | 50 +++++
 rtl/mc_controller.sv | 247 ++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the mc_controller microcode sequencer.
// Holds the FSM state enum, opcode constants, mux encodings and the instruction decoder.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_ALUI = 2'b01;
    localparam logic [1:0] CLS_MEM  = 2'b10;
    localparam logic [1:0] CLS_CTL  = 2'b11;

    localparam logic [2:0] SUB_LDM = 3'b000;
    localparam logic [2:0] SUB_STM = 3'b001;
    localparam logic [2:0] SUB_JMP = 3'b000;
    localparam logic [2:0] SUB_BZ  = 3'b001;
    localparam logic [2:0] SUB_BC  = 3'b010;
    localparam logic [2:0] SUB_NOP = 3'b011;
    localparam logic [2:0] SUB_JSR = 3'b100;
    localparam logic [2:0] SUB_RET = 3'b101;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RET    = 2'b10;

    localparam logic [1:0] WR_ALU   = 2'b00;
    localparam logic [1:0] WR_MEM   = 2'b01;
    localparam logic [1:0] WR_SHIFT = 2'b10;

    typedef struct packed {
        logic       alu;
        logic       ld;
        logic       st;
        logic       shift;
        logic       ctl;
        logic       illegal;
        logic [1:0] wsel;
    } dec_t;

    // JSR/RET are only legal encodings when the return-address stack is built in.
    function automatic dec_t decode(logic [1:0] cls, logic [2:0] sub, logic sub_en);
        dec_t d;
        d = '0;
        case (cls)
            CLS_ALU, CLS_ALUI: begin
                d.alu  = 1'b1;
                d.wsel = WR_ALU;
            end
            CLS_MEM: begin
                if (sub == SUB_LDM) begin
                    d.ld   = 1'b1;
                    d.wsel = WR_MEM;
                end else if (sub == SUB_STM) begin
                    d.st = 1'b1;
                end else if (sub[2]) begin
                    d.shift = 1'b1;
                    d.wsel  = WR_SHIFT;
                end else begin
                    d.illegal = 1'b1;
                end
            end
            CLS_CTL: begin
                d.ctl = 1'b1;
                if (sub[2:1] == 2'b11) begin
                    d.illegal = 1'b1;
                end else if ((sub[2:1] == 2'b10) && !sub_en) begin
                    d.illegal = 1'b1;
                end else begin
                    d.illegal = 1'b0;
                end
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_ctrl_ras.sv
// Return-address stack (LIFO) for JSR/RET; only instantiated when
// MC_CTRL_SUBROUTINE_EN is defined. Overflow/underflow requests are ignored here.
module mc_ctrl_ras #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);
    import mc_ctrl_pkg::*;

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  count;
    logic [PTR_W-1:0]  top_ptr;

    assign full    = (count == PTR_W'(DEPTH));
    assign empty   = (count == '0);
    assign top_ptr = count - 1'b1;
    assign top     = empty ? '0 : mem[top_ptr[IDX_W-1:0]];

    // Occupancy counter; the entries themselves need no reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end else begin
            count <= count;
        end
    end

    // Entry write at the current fill level
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/writeback with handshake timeout
// and sticky fault. Define MC_CTRL_SUBROUTINE_EN to build in JSR/RET and the return-address stack.
module mc_controller #(
    parameter int INSTR_W     = 19,
    parameter int ADDR_W      = 12,
    parameter int MEM_TIMEOUT = 15,
    parameter int RAS_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_ready,
    input  logic               zero_in,
    input  logic               carry_in,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               mem_read,
    output logic               ldm,
    output logic               stm,
    output logic               ir_we,
    output logic               reg_we,
    output logic               en_pc,
    output logic [1:0]         pc_src,
    output logic               en_zero,
    output logic               en_carry,
    output logic [1:0]         sel_to_write,
    output logic               sel_r2,
    output logic               sel_alu_arg,
    output logic [2:0]         alu_fn,
    output logic [1:0]         sh_ro_fn,
    output logic [ADDR_W-1:0]  ras_addr,
    output logic               fault
);
    import mc_ctrl_pkg::*;

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t             state;
    state_t             state_next;
    logic [INSTR_W-1:0] ir;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         cls;
    logic [2:0]         sub;
    dec_t               dec;
    logic               wait_state;
    logic               timed_out;
    logic               field_phase;
    logic [ADDR_W-1:0]  ras_top;
    logic               ras_full;
    logic               ras_empty;
    logic               unused_bits;

    assign cls         = ir[INSTR_W-1 -: 2];
    assign sub         = ir[INSTR_W-3 -: 3];
    assign wait_state  = (state == ST_FETCH) || (state == ST_MEM);
    assign timed_out   = wait_state && !mem_ready && (cnt == CNT_W'(MEM_TIMEOUT));
    assign field_phase = (state == ST_DECODE) || (state == ST_EXEC) ||
                         (state == ST_MEM)    || (state == ST_WB);
    assign unused_bits = ^{pc_in, ir[INSTR_W-6:0]};

`ifdef MC_CTRL_SUBROUTINE_EN
    localparam logic SUB_EN = 1'b1;
    logic ras_push;
    logic ras_pop;

    // Stack only moves when the PC update actually happens (not on overflow/underflow)
    assign ras_push = (state == ST_EXEC) && dec.ctl && (sub == SUB_JSR) && !ras_full;
    assign ras_pop  = (state == ST_EXEC) && dec.ctl && (sub == SUB_RET) && !ras_empty;

    mc_ctrl_ras #(
        .DEPTH  (RAS_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_in),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );
`else
    localparam logic SUB_EN = 1'b0;
    assign ras_top   = '0;
    assign ras_full  = 1'b0;
    assign ras_empty = 1'b1;
`endif

    assign dec = decode(cls, sub, SUB_EN);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Instruction register, loaded on a completed fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= '0;
        end else if (ir_we) begin
            ir <= instr;
        end else begin
            ir <= ir;
        end
    end

    // Handshake wait counter: restarts on every state change, counts stalled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (wait_state && !mem_ready) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= cnt;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next   = state;
        mem_read     = 1'b0;
        ldm          = 1'b0;
        stm          = 1'b0;
        ir_we        = 1'b0;
        reg_we       = 1'b0;
        en_pc        = 1'b0;
        pc_src       = PC_INC;
        en_zero      = 1'b0;
        en_carry     = 1'b0;
        sel_to_write = WR_ALU;
        sel_r2       = 1'b0;
        sel_alu_arg  = 1'b0;
        alu_fn       = 3'b000;
        sh_ro_fn     = 2'b00;
        ras_addr     = ras_top;
        fault        = 1'b0;

        if (field_phase) begin
            alu_fn       = dec.alu ? sub : 3'b000;
            sh_ro_fn     = dec.shift ? sub[1:0] : 2'b00;
            sel_alu_arg  = (cls == CLS_ALUI);
            sel_r2       = dec.st;
            sel_to_write = dec.wsel;
        end else begin
            alu_fn = 3'b000;
        end

        case (state)
            ST_IDLE: begin
                ras_addr   = '0;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    en_pc      = 1'b1;
                    pc_src     = PC_INC;
                    state_next = ST_DECODE;
                end else if (timed_out) begin
                    state_next = ST_FAULT;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_DECODE: begin
                state_next = dec.illegal ? ST_FAULT : ST_EXEC;
            end
            ST_EXEC: begin
                if (dec.alu || dec.shift) begin
                    en_zero    = 1'b1;
                    en_carry   = 1'b1;
                    state_next = ST_WB;
                end else if (dec.ld || dec.st) begin
                    state_next = ST_MEM;
                end else if (dec.ctl) begin
                    state_next = ST_FETCH;
                    case (sub)
                        SUB_JMP: begin
                            en_pc  = 1'b1;
                            pc_src = PC_BRANCH;
                        end
                        SUB_BZ: begin
                            en_pc  = zero_in;
                            pc_src = zero_in ? PC_BRANCH : PC_INC;
                        end
                        SUB_BC: begin
                            en_pc  = carry_in;
                            pc_src = carry_in ? PC_BRANCH : PC_INC;
                        end
                        SUB_JSR: begin
                            if (ras_full) begin
                                state_next = ST_FAULT;
                            end else begin
                                en_pc  = 1'b1;
                                pc_src = PC_BRANCH;
                            end
                        end
                        SUB_RET: begin
                            if (ras_empty) begin
                                state_next = ST_FAULT;
                            end else begin
                                en_pc  = 1'b1;
                                pc_src = PC_RET;
                            end
                        end
                        default: state_next = ST_FETCH;
                    endcase
                end else begin
                    state_next = ST_FAULT;
                end
            end
            ST_MEM: begin
                mem_read = dec.ld;
                ldm      = dec.ld;
                stm      = dec.st;
                if (mem_ready) begin
                    state_next = dec.ld ? ST_WB : ST_FETCH;
                end else if (timed_out) begin
                    state_next = ST_FAULT;
                end else begin
                    state_next = ST_MEM;
                end
            end
            ST_WB: begin
                reg_we     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_FAULT: begin
                ras_addr   = '0;
                fault      = 1'b1;
                state_next = ST_FAULT;
            end
            default: begin
                ras_addr   = '0;
                state_next = ST_FAULT;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: a transaction-level model expands each
// instruction into its expected per-cycle outputs; one negedge process compares.
module tb_mc_controller;

    localparam int INSTR_W     = 19;
    localparam int ADDR_W      = 12;
    localparam int MEM_TIMEOUT = 15;
    localparam int RAS_DEPTH   = 4;

    typedef struct packed {
        logic              mem_read;
        logic              ldm;
        logic              stm;
        logic              ir_we;
        logic              reg_we;
        logic              en_pc;
        logic [1:0]        pc_src;
        logic              en_zero;
        logic              en_carry;
        logic [1:0]        sel_to_write;
        logic              sel_r2;
        logic              sel_alu_arg;
        logic [2:0]        alu_fn;
        logic [1:0]        sh_ro_fn;
        logic [ADDR_W-1:0] ras_addr;
        logic              fault;
    } outs_t;

    logic               clk;
    logic               rst;
    logic [INSTR_W-1:0] instr;
    logic               mem_ready;
    logic               zero_in;
    logic               carry_in;
    logic [ADDR_W-1:0]  pc_in;
    logic               mem_read, ldm, stm, ir_we, reg_we, en_pc;
    logic [1:0]         pc_src;
    logic               en_zero, en_carry;
    logic [1:0]         sel_to_write;
    logic               sel_r2, sel_alu_arg;
    logic [2:0]         alu_fn;
    logic [1:0]         sh_ro_fn;
    logic [ADDR_W-1:0]  ras_addr;
    logic               fault;
    outs_t              act;

    mc_controller #(
        .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .MEM_TIMEOUT(MEM_TIMEOUT), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .zero_in(zero_in), .carry_in(carry_in), .pc_in(pc_in),
        .mem_read(mem_read), .ldm(ldm), .stm(stm), .ir_we(ir_we), .reg_we(reg_we),
        .en_pc(en_pc), .pc_src(pc_src), .en_zero(en_zero), .en_carry(en_carry),
        .sel_to_write(sel_to_write), .sel_r2(sel_r2), .sel_alu_arg(sel_alu_arg),
        .alu_fn(alu_fn), .sh_ro_fn(sh_ro_fn), .ras_addr(ras_addr), .fault(fault)
    );

    assign act = {mem_read, ldm, stm, ir_we, reg_we, en_pc, pc_src, en_zero, en_carry,
                  sel_to_write, sel_r2, sel_alu_arg, alu_fn, sh_ro_fn, ras_addr, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    outs_t       exp_q[$];
    string       name_q[$];
    string       lit_name[$];
    int          lit_got[$];
    int          lit_exp[$];
    logic [11:0] m_ras[$];
    int          passed = 0;
    int          total = 0;
    int          ldm_cnt = 0;
    int          rd_cnt = 0;
    int          n_cyc = 0;
    int          cyc_limit = 1000;

    // The single compare process: per-cycle model expectations plus queued literal checks
    always @(negedge clk) begin
        outs_t e;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (act === e) passed++;
            else $display("FAIL %s: dut=%h model=%h", nm, act, e);
            if (ldm) ldm_cnt++;
            if (mem_read) rd_cnt++;
        end
        while (lit_name.size() > 0) begin
            nm = lit_name.pop_front();
            total++;
            if (lit_got[0] == lit_exp[0]) passed++;
            else $display("FAIL %s: got %0d expected %0d", nm, lit_got[0], lit_exp[0]);
            void'(lit_got.pop_front());
            void'(lit_exp.pop_front());
        end
    end

    task automatic lit(input string nm, input int got, input int expv);
        lit_name.push_back(nm);
        lit_got.push_back(got);
        lit_exp.push_back(expv);
    endtask

    task automatic emit(input outs_t e, input logic mr, input string nm);
        if (n_cyc < cyc_limit) begin
            mem_ready = mr;
            exp_q.push_back(e);
            name_q.push_back(nm);
            n_cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic outs_t idle_o();
        outs_t o;
        o = '0;
        if (m_ras.size() > 0) o.ras_addr = m_ras[$];
        return o;
    endfunction

    function automatic outs_t fields(input logic [18:0] ins);
        outs_t o;
        logic [1:0] cls;
        logic [2:0] sub;
        o   = idle_o();
        cls = ins[18:17];
        sub = ins[16:14];
        if (cls == 2'b00) o.alu_fn = sub;
        else if (cls == 2'b01) begin o.alu_fn = sub; o.sel_alu_arg = 1'b1; end
        else if (cls == 2'b10 && sub == 3'b000) o.sel_to_write = 2'b01;
        else if (cls == 2'b10 && sub == 3'b001) o.sel_r2 = 1'b1;
        else if (cls == 2'b10 && sub[2]) begin o.sh_ro_fn = sub[1:0]; o.sel_to_write = 2'b10; end
        return o;
    endfunction

    task automatic enter_fault(input int n);
        outs_t o;
        for (int i = 0; i < n; i++) begin
            o = '0;
            o.fault = 1'b1;
            emit(o, 1'b1, "fault");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_ras.delete();
        n_cyc = 0;
        cyc_limit = 1000;
        for (int i = 0; i < 5; i++) emit('0, 1'b1, "reset");
        rst = 1'b0;
        emit('0, 1'b1, "idle");
    endtask

    // Expands one instruction into its expected cycle-by-cycle behaviour
    task automatic run_instr(input logic [18:0] ins, input int fw, input int mw, input logic z,
                             input logic c, input logic [11:0] pc, input int limit);
        outs_t o, f;
        logic [1:0] cls;
        logic [2:0] sub;
        logic illegal;
        instr = ins; zero_in = z; carry_in = c; pc_in = pc;
        n_cyc = 0; cyc_limit = limit;
        cls = ins[18:17];
        sub = ins[16:14];
        for (int k = 0; k < fw && k < 16; k++) begin
            o = idle_o(); o.mem_read = 1'b1;
            emit(o, 1'b0, "fetch_wait");
        end
        if (fw >= 16) begin enter_fault(3); return; end
        o = idle_o(); o.mem_read = 1'b1; o.ir_we = 1'b1; o.en_pc = 1'b1;
        emit(o, 1'b1, "fetch");
        f = fields(ins);
        emit(f, 1'b1, "decode");
        illegal = (cls == 2'b10 && sub[2:1] == 2'b01) || (cls == 2'b11 && sub[2:1] == 2'b11);
`ifndef MC_CTRL_SUBROUTINE_EN
        if (cls == 2'b11 && sub[2:1] == 2'b10) illegal = 1'b1;
`endif
        if (illegal) begin enter_fault(3); return; end
        o = f;
        if (cls == 2'b11) begin
            if (sub == 3'b100) begin
                if (m_ras.size() == RAS_DEPTH) begin emit(o, 1'b1, "exec_jsr_full"); enter_fault(3); return; end
                o.en_pc = 1'b1; o.pc_src = 2'b01;
                emit(o, 1'b1, "exec_jsr");
                m_ras.push_back(pc);
                return;
            end
            if (sub == 3'b101) begin
                if (m_ras.size() == 0) begin emit(o, 1'b1, "exec_ret_empty"); enter_fault(3); return; end
                o.en_pc = 1'b1; o.pc_src = 2'b10;
                emit(o, 1'b1, "exec_ret");
                void'(m_ras.pop_back());
                return;
            end
            if (sub == 3'b000 || (sub == 3'b001 && z) || (sub == 3'b010 && c)) begin
                o.en_pc = 1'b1; o.pc_src = 2'b01;
            end
            emit(o, 1'b1, "exec_ctl");
            return;
        end
        if (cls == 2'b10 && sub[2:1] == 2'b00) begin
            emit(f, 1'b1, "exec_mem");
            o = f;
            if (sub == 3'b000) begin o.mem_read = 1'b1; o.ldm = 1'b1; end
            else o.stm = 1'b1;
            for (int k = 0; k < mw && k < 16; k++) emit(o, 1'b0, "mem_wait");
            if (mw >= 16) begin enter_fault(3); return; end
            emit(o, 1'b1, "mem");
            if (sub == 3'b001) return;
        end else begin
            o.en_zero = 1'b1; o.en_carry = 1'b1;
            emit(o, 1'b1, "exec_alu");
        end
        o = fields(ins); o.reg_we = 1'b1;
        emit(o, 1'b1, "wb");
    endtask

    initial begin
        int b;
        rst = 1'b1; mem_ready = 1'b1; instr = '0; zero_in = 1'b0; carry_in = 1'b0; pc_in = '0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(19'b00_010_00000000000000, 0, 0, 1'b0, 1'b0, 12'h001, 1000);
        lit("alu_latency", n_cyc, 4);
        run_instr(19'b01_101_00000000001111, 2, 0, 1'b0, 1'b0, 12'h002, 1000);
        lit("alui_latency", n_cyc, 6);
        run_instr(19'b10_110_00000000000000, 0, 0, 1'b0, 1'b0, 12'h003, 1000);
        lit("shift_latency", n_cyc, 4);
        b = ldm_cnt;
        run_instr(19'b10_000_00000000000101, 0, 3, 1'b0, 1'b0, 12'h004, 1000);
        lit("ldm_latency", n_cyc, 8);
        lit("ldm_strobes", ldm_cnt - b, 4);
        run_instr(19'b10_001_00000000000101, 0, 0, 1'b0, 1'b0, 12'h005, 1000);
        lit("stm_latency", n_cyc, 4);
        run_instr(19'b11_001_00000000000000, 0, 0, 1'b1, 1'b0, 12'h006, 1000);
        lit("bz_taken_latency", n_cyc, 3);
        run_instr(19'b11_001_00000000000000, 0, 0, 1'b0, 1'b1, 12'h007, 1000);
        lit("bz_not_taken_latency", n_cyc, 3);
        run_instr(19'b11_010_00000000000000, 0, 0, 1'b0, 1'b1, 12'h008, 1000);
        run_instr(19'b11_010_00000000000000, 0, 0, 1'b1, 1'b0, 12'h009, 1000);
        run_instr(19'b11_000_00000000000000, 0, 0, 1'b0, 1'b0, 12'h00A, 1000);
        run_instr(19'b11_011_00000000000000, 0, 0, 1'b1, 1'b1, 12'h00B, 1000);
        run_instr(19'b00_111_00000000000000, 15, 0, 1'b0, 1'b0, 12'h00C, 1000);
        lit("fetch_ready_on_16th", n_cyc, 19);

`ifdef MC_CTRL_SUBROUTINE_EN
        run_instr(19'b11_100_00000000000000, 0, 0, 1'b0, 1'b0, 12'h0A5, 1000);
        lit("ras_model_top", int'(m_ras[$]), 'h0A5);
        run_instr(19'b11_101_00000000000000, 0, 0, 1'b0, 1'b0, 12'h0B0, 1000);
        lit("ras_model_empty", m_ras.size(), 0);
        for (int i = 0; i < 4; i++)
            run_instr(19'b11_100_00000000000000, 0, 0, 1'b0, 1'b0, 12'h100 + 12'(i), 1000);
        run_instr(19'b11_100_00000000000000, 0, 0, 1'b0, 1'b0, 12'h1FF, 1000);
        lit("jsr_overflow_cycles", n_cyc, 6);
        do_reset();
        run_instr(19'b11_101_00000000000000, 0, 0, 1'b0, 1'b0, 12'h010, 1000);
`else
        run_instr(19'b11_100_00000000000000, 0, 0, 1'b0, 1'b0, 12'h0A5, 1000);
        lit("jsr_illegal_cycles", n_cyc, 5);
`endif
        do_reset();
        run_instr(19'b10_000_00000000000000, 0, 16, 1'b0, 1'b0, 12'h020, 1000);
        do_reset();
        run_instr(19'b10_010_00000000000000, 0, 0, 1'b0, 1'b0, 12'h030, 1000);
        do_reset();
        run_instr(19'b11_111_00000000000000, 0, 0, 1'b0, 1'b0, 12'h031, 1000);
        do_reset();
        b = rd_cnt;
        run_instr(19'b00_000_00000000000000, 16, 0, 1'b0, 1'b0, 12'h040, 1000);
        lit("fetch_timeout_reads", rd_cnt - b, 16);
        enter_fault(5);
        do_reset();
        run_instr(19'b10_000_00000000000000, 0, 10, 1'b0, 1'b0, 12'h050, 5);
        do_reset();
        run_instr(19'b00_001_00000000000000, 0, 0, 1'b1, 1'b1, 12'h060, 1000);
        lit("restart_alu_latency", n_cyc, 4);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
